// File: rtl/sc_matrix_scan.sv
// Row-multiplexing LED matrix scanner. Each row gets a blank interval and then a dwell
// period. An active-low strobe marks the start of each frame.
module sc_matrix_scan #(
    parameter int MATRIX_SCAN_DATAWIDTH = 8,
    parameter int MATRIX_SCAN_ROWS      = 8,
    parameter int MATRIX_SCAN_DWELL     = 50000,
    parameter int MATRIX_SCAN_BLANK     = 50
) (
    input  logic                                              SC_MATRIX_SCAN_CLOCK_50,
    input  logic                                              SC_MATRIX_SCAN_RESET_InHigh,
    input  logic                                              SC_MATRIX_SCAN_enable_InLow,
    input  logic [MATRIX_SCAN_ROWS*MATRIX_SCAN_DATAWIDTH-1:0] SC_MATRIX_SCAN_data_InBUS,
    output logic [MATRIX_SCAN_ROWS-1:0]                       SC_MATRIX_SCAN_row_OutBUS,
    output logic [MATRIX_SCAN_DATAWIDTH-1:0]                  SC_MATRIX_SCAN_col_OutBUS,
    output logic                                              SC_MATRIX_SCAN_frame_OutLow
);

    localparam int COUNT_MAX = (MATRIX_SCAN_DWELL > MATRIX_SCAN_BLANK) ? MATRIX_SCAN_DWELL
                                                                       : MATRIX_SCAN_BLANK;
    localparam int COUNT_W   = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam int INDEX_W   = $clog2(MATRIX_SCAN_ROWS);

    localparam logic [COUNT_W-1:0]          BLANK_LAST = COUNT_W'(MATRIX_SCAN_BLANK - 1);
    localparam logic [COUNT_W-1:0]          DWELL_LAST = COUNT_W'(MATRIX_SCAN_DWELL - 1);
    localparam logic [INDEX_W-1:0]          ROW_LAST   = INDEX_W'(MATRIX_SCAN_ROWS - 1);
    localparam logic [MATRIX_SCAN_ROWS-1:0] ROW_ONE    = MATRIX_SCAN_ROWS'(1);

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_BLANK,
        SCAN_DRIVE
    } scanState_t;

    scanState_t                       scanState;
    logic [INDEX_W-1:0]               rowIndex;
    logic [COUNT_W-1:0]               phaseCount;
    logic [MATRIX_SCAN_DATAWIDTH-1:0] colSnapshot;
    logic [MATRIX_SCAN_DATAWIDTH-1:0] rowSlices [MATRIX_SCAN_ROWS];

    for (genvar r = 0; r < MATRIX_SCAN_ROWS; r++) begin : gSlice
        assign rowSlices[r] = SC_MATRIX_SCAN_data_InBUS[r*MATRIX_SCAN_DATAWIDTH +: MATRIX_SCAN_DATAWIDTH];
    end

    // Disable overrides every state, so a re-enable always restarts at row 0 with a full blank
    always_ff @(posedge SC_MATRIX_SCAN_CLOCK_50 or posedge SC_MATRIX_SCAN_RESET_InHigh) begin
        if (SC_MATRIX_SCAN_RESET_InHigh) begin
            scanState   <= SCAN_IDLE;
            rowIndex    <= '0;
            phaseCount  <= '0;
            colSnapshot <= '0;
        end else if (SC_MATRIX_SCAN_enable_InLow) begin
            scanState  <= SCAN_IDLE;
            rowIndex   <= '0;
            phaseCount <= '0;
        end else begin
            case (scanState)
                SCAN_IDLE: begin
                    scanState  <= SCAN_BLANK;
                    rowIndex   <= '0;
                    phaseCount <= '0;
                end
                SCAN_BLANK: begin
                    if (phaseCount == BLANK_LAST) begin
                        scanState   <= SCAN_DRIVE;
                        phaseCount  <= '0;
                        colSnapshot <= rowSlices[rowIndex];
                    end else begin
                        phaseCount <= phaseCount + 1'b1;
                    end
                end
                SCAN_DRIVE: begin
                    if (phaseCount == DWELL_LAST) begin
                        scanState  <= SCAN_BLANK;
                        phaseCount <= '0;
                        rowIndex   <= (rowIndex == ROW_LAST) ? '0 : rowIndex + 1'b1;
                    end else begin
                        phaseCount <= phaseCount + 1'b1;
                    end
                end
                default: begin
                    scanState  <= SCAN_IDLE;
                    rowIndex   <= '0;
                    phaseCount <= '0;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, so an async reset blanks them at once
    always_comb begin
        SC_MATRIX_SCAN_row_OutBUS   = '0;
        SC_MATRIX_SCAN_col_OutBUS   = '0;
        SC_MATRIX_SCAN_frame_OutLow = 1'b1;
        if (scanState == SCAN_DRIVE) begin
            SC_MATRIX_SCAN_row_OutBUS   = ROW_ONE << rowIndex;
            SC_MATRIX_SCAN_col_OutBUS   = colSnapshot;
            SC_MATRIX_SCAN_frame_OutLow = !((rowIndex == '0) && (phaseCount == '0));
        end
    end

endmodule

// File: tb/tb_sc_matrix_scan.sv
// Scoreboard bench for sc_matrix_scan. An abstract timing model queues the expected
// outputs for each cycle, and a negedge monitor compares them against the DUT.
module tb_sc_matrix_scan;

    localparam int DW     = 8;
    localparam int ROWS   = 8;
    localparam int DWELL  = 4;
    localparam int BLANK  = 2;
    localparam int PERIOD = BLANK + DWELL;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 enableLow;
    logic [ROWS*DW-1:0]   data;
    logic [ROWS-1:0]      rowBus;
    logic [DW-1:0]        colBus;
    logic                 frameLow;

    typedef struct packed {
        logic [ROWS-1:0] row;
        logic [DW-1:0]   col;
        logic            frame;
    } expect_t;

    expect_t            expQ[$];
    expect_t            monExp;
    int                 total = 0;
    int                 bad = 0;
    bit                 modelRunning = 1'b0;
    int                 modelPos = 0;
    logic [DW-1:0]      modelShown = '0;
    logic [ROWS*DW-1:0] d;

    sc_matrix_scan #(
        .MATRIX_SCAN_DATAWIDTH(DW),
        .MATRIX_SCAN_ROWS(ROWS),
        .MATRIX_SCAN_DWELL(DWELL),
        .MATRIX_SCAN_BLANK(BLANK)
    ) dut (
        .SC_MATRIX_SCAN_CLOCK_50(clock),
        .SC_MATRIX_SCAN_RESET_InHigh(reset),
        .SC_MATRIX_SCAN_enable_InLow(enableLow),
        .SC_MATRIX_SCAN_data_InBUS(data),
        .SC_MATRIX_SCAN_row_OutBUS(rowBus),
        .SC_MATRIX_SCAN_col_OutBUS(colBus),
        .SC_MATRIX_SCAN_frame_OutLow(frameLow)
    );

    always #5 clock = ~clock;

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, required, $time);
        end
    endfunction

    // Position-in-frame model: the row and phase come from the cycle count since enable,
    // and the displayed columns are latched from data at the first drive cycle of each row.
    function automatic void modelStep();
        expect_t e;
        int      r;
        int      w;
        if (reset || enableLow) begin
            modelRunning = 1'b0;
        end else if (!modelRunning) begin
            modelRunning = 1'b1;
            modelPos     = 0;
        end else begin
            modelPos++;
        end
        e.row   = '0;
        e.col   = '0;
        e.frame = 1'b1;
        if (modelRunning) begin
            r = (modelPos / PERIOD) % ROWS;
            w = modelPos % PERIOD;
            if (w == BLANK) modelShown = data[r*DW +: DW];
            if (w >= BLANK) begin
                e.row   = ROWS'(1) << r;
                e.col   = modelShown;
                e.frame = !((r == 0) && (w == BLANK));
            end
        end
        expQ.push_back(e);
    endfunction

    task automatic applyStimulus(input logic en, input logic [ROWS*DW-1:0] dv);
        enableLow = en;
        data      = dv;
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic runCycles(input logic en, input int n);
        for (int i = 0; i < n; i++) applyStimulus(en, d);
    endtask

    always @(negedge clock) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("row", 32'(rowBus), 32'(monExp.row));
            checkOutput("col", 32'(colBus), 32'(monExp.col));
            checkOutput("frame", 32'(frameLow), 32'(monExp.frame));
            checkOutput("oneHot", 32'($countones(rowBus) <= 1), 32'd1);
            if (rowBus == '0) checkOutput("blankCol", 32'(colBus), 32'd0);
        end
    end

    initial begin
        enableLow = 1'b1;
        d = {$urandom, $urandom};
        d[7:0]  = 8'h81;
        d[15:8] = 8'h42;
        data = d;
        #1 reset = 1'b1;
        #1;
        checkOutput("resetRow", 32'(rowBus), 32'd0);
        checkOutput("resetCol", 32'(colBus), 32'd0);
        checkOutput("resetFrame", 32'(frameLow), 32'd1);
        runCycles(1'b1, 2);
        reset = 1'b0;
        runCycles(1'b1, 3);

        // basic scan, snapshot hold on row 0, then two full frames to cover the wrap
        runCycles(1'b0, 3);
        d[7:0] = 8'hFF;
        runCycles(1'b0, 2 * ROWS * PERIOD + 4);

        // disable during row 3 drive, then re-enable
        runCycles(1'b1, 2);
        runCycles(1'b0, 3 * PERIOD + BLANK + 1);
        runCycles(1'b1, 4);
        runCycles(1'b0, 10);

        // async reset mid-drive of row 3, applied away from the monitor's sample point
        runCycles(1'b1, 2);
        runCycles(1'b0, 3 * PERIOD + BLANK + 1);
        #5;
        reset = 1'b1;
        #1;
        checkOutput("asyncRow", 32'(rowBus), 32'd0);
        checkOutput("asyncCol", 32'(colBus), 32'd0);
        checkOutput("asyncFrame", 32'(frameLow), 32'd1);
        runCycles(1'b0, 3);
        reset = 1'b0;
        runCycles(1'b1, 20);

        // one-cycle enable pulse, and a disable during blank
        runCycles(1'b0, 1);
        runCycles(1'b1, 5);
        runCycles(1'b0, 2);
        runCycles(1'b1, 5);

        // random enable drops and data reloads
        runCycles(1'b0, 1);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) d = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 59) == 0), d);
        end

        runCycles(1'b1, 2);
        #10;
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sc_matrix_scan.md
# sc_matrix_scan

Row-multiplexing scanner for the LED matrix display. It sits directly downstream of the bank of matrix row registers. It takes their concatenated outputs and drives one row at a time, holding each row for a fixed dwell time. A blanking interval precedes every row to prevent ghosting. Once per frame it emits an active-low strobe that upstream logic can use to time register loads.

## Interface

Parameters:
- MATRIX_SCAN_DATAWIDTH, 8: columns per row, equal to the row register width.
- MATRIX_SCAN_ROWS, 8: number of rows. Must be ≥ 2.
- MATRIX_SCAN_DWELL, 50000: clock cycles each row is driven. Must be ≥ 1.
- MATRIX_SCAN_BLANK, 50: clock cycles of all-off before each row. Must be ≥ 1.

Ports:
- SC_MATRIX_SCAN_CLOCK_50, in, 1: the single clock; all state changes on its rising edge.
- SC_MATRIX_SCAN_RESET_InHigh, in, 1: reset, asynchronous and active-high.
- SC_MATRIX_SCAN_enable_InLow, in, 1: 0 = scan; 1 = stop and blank.
- SC_MATRIX_SCAN_data_InBUS, in, ROWS*DATAWIDTH: row r is bits [r*DATAWIDTH +: DATAWIDTH]. Driven from the row register outputs.
- SC_MATRIX_SCAN_row_OutBUS, out, ROWS: one-hot row select, active-high.
- SC_MATRIX_SCAN_col_OutBUS, out, DATAWIDTH: column data for the active row, active-high (1 = LED on).
- SC_MATRIX_SCAN_frame_OutLow, out, 1: one-cycle low pulse at the start of the row-0 drive period.

## Operation

- Registered state: FSM state (IDLE, BLANK, DRIVE), row index, dwell/blank counter, column snapshot register.
  - Counter width: clog2(max(DWELL, BLANK)).
  - Index width: clog2(ROWS).
- All outputs are decoded only from registered state. There is no combinational path from any input to any output.
- IDLE:
  - Outputs: row = 0, col = 0, frame = 1.
  - If enable_InLow is sampled 0, go to BLANK with index = 0 and counter = 0.
- BLANK:
  - Outputs: row = 0, col = 0.
  - Counter increments each cycle.
  - On the cycle with counter == BLANK-1:
    - go to DRIVE and clear the counter;
    - load the snapshot with data_InBUS slice[index] on that same edge.
- DRIVE:
  - Outputs: row = one-hot(index), col = snapshot.
  - The snapshot is held for the whole dwell. Input changes during DRIVE are not visible until that row's next visit.
  - On counter == DWELL-1:
    - go to BLANK and clear the counter;
    - advance the index, wrapping from ROWS-1 to 0.
- frame_OutLow = 0 only when state == DRIVE, index == 0 and counter == 0; otherwise 1.
- enable_InLow sampled 1 in any state:
  - next state is IDLE;
  - index and counter are cleared;
  - outputs are blank from the following cycle.
  - Re-enabling always restarts at row 0 with a full blank interval.
- Reset (asynchronous, at any time, including mid-DRIVE):
  - state = IDLE, index = 0, counter = 0, snapshot = 0;
  - outputs immediately row = 0, col = 0, frame = 1.

## Timing

- Latency from enable_InLow sampled 0 in IDLE:
  - BLANK for the next BLANK cycles;
  - row 0 then drives for DWELL cycles.
- Row period = BLANK + DWELL cycles.
- Frame period = ROWS*(BLANK + DWELL) cycles.
- Exactly one frame pulse per frame.
- At most one row bit is ever high. row and col are never nonzero during BLANK or IDLE.
- Snapshot data is the value of data_InBUS sampled at the BLANK→DRIVE edge.
- Upstream loads performed in response to a frame pulse are first displayed on each row's next visit.
- Reset values of all outputs: row_OutBUS = 0, col_OutBUS = 0, frame_OutLow = 1.

## Test plan

All scenarios use DATAWIDTH=8, ROWS=8, DWELL=4, BLANK=2.

1. Reset: assert reset mid-DRIVE on row 3 → row=0x00, col=0x00, frame=1 immediately, without waiting for a clock edge. After release with enable=1, outputs stay blank indefinitely.
2. Basic scan: row0=0x81, row1=0x42, enable→0.
   - Blank for 2 cycles, then row=0x01, col=0x81 for 4 cycles.
   - frame is low only in the first of those cycles.
   - Blank for 2 cycles, then row=0x02, col=0x42 for 4 cycles.
3. Wrap: run a full frame → row steps 0x01…0x80, then returns to 0x01. frame pulses exactly every 48 cycles. The checker confirms one-hot/zero on every cycle.
4. Snapshot hold: change row0 from 0x81 to 0xFF in the 2nd DRIVE cycle of row 0 → col stays 0x81 until row 0 ends. The next visit of row 0 shows 0xFF.
5. Disable mid-scan: enable→1 during DRIVE of row 3 (row=0x08) → next cycle row=0x00, col=0x00.
   - Re-enable gives 2 blank cycles, then row=0x01 with a frame pulse.
6. Disable during BLANK, and an enable pulse held low for only 1 cycle → IDLE is reached. No row is ever driven and no frame pulse occurs.
